mole_game_ctrl: RTL and testbench

MOLE_GAME_CTRL -- requirements
Module: mole_game_ctrl

---
 rtl/mole_game_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_mole_game_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mole_game_ctrl.sv
// mole_game_ctrl: whack-a-mole game controller.
// Synchronizes the whack switches and start button, runs a tick-paced round,
// pops moles from an LFSR, and keeps a saturating 0..99 score plus its BCD digits.
// Optional build macro: WRONG_HIT_PENALTY_EN -- whacking an empty hole in play
// costs one point (saturating at 0); undefined, such whacks are ignored.
module mole_game_ctrl #(
    parameter int TICK_DIV   = 25000000,
    parameter int GAME_TICKS = 60
) (
    input  logic       dclk,
    input  logic       clr_n,
    input  logic [3:0] sw,
    input  logic       start,
    output logic [3:0] mole,
    output logic [6:0] score,
    output logic [3:0] score_tens,
    output logic [3:0] score_ones,
    output logic [1:0] state,
    output logic       tick
);

    localparam int CNT_W = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        OVER = 2'b10,
        BAD  = 2'b11
    } state_t;

    state_t            st, st_nx;
    logic [3:0]        sw_p0, sw_p1, sw_p2;
    logic              start_p0, start_p1, start_p2;
    logic [3:0]        hit;
    logic              go;
    logic [15:0]       lfsr;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [7:0]        rnd, rnd_nx;
    logic [3:0]        mole_nx;
    logic [6:0]        score_nx;
    logic [2:0]        nhit, nmiss, nwrong;
    logic signed [7:0] score_sum;

    // Clamp a signed running score into the displayable 0..99 range
    function automatic logic [6:0] sat_score(input logic signed [7:0] v);
        if (v < 8'sd0) begin
            return 7'd0;
        end else if (v > 8'sd99) begin
            return 7'd99;
        end else begin
            return v[6:0];
        end
    endfunction

    assign state = st;
    assign hit   = sw_p1 & ~sw_p2;
    assign go    = start_p1 & ~start_p2;
    assign tick  = (st == PLAY) && (cnt == CNT_W'(TICK_DIV - 1));

    // Two-flop synchronizers followed by one delay flop for rising-edge detection
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            sw_p0    <= '0;
            sw_p1    <= '0;
            sw_p2    <= '0;
            start_p0 <= 1'b0;
            start_p1 <= 1'b0;
            start_p2 <= 1'b0;
        end else begin
            sw_p0    <= sw;
            sw_p1    <= sw_p0;
            sw_p2    <= sw_p1;
            start_p0 <= start;
            start_p1 <= start_p0;
            start_p2 <= start_p1;
        end
    end

    // Free-running Fibonacci LFSR (taps 16,14,13,11), right-shifting
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        end
    end

    // Next-state and game datapath: whacks beat same-cycle ticks per hole
    always_comb begin
        st_nx     = st;
        mole_nx   = mole;
        score_nx  = score;
        rnd_nx    = rnd;
        cnt_nx    = '0;
        nhit      = '0;
        nmiss     = '0;
        nwrong    = '0;
        score_sum = $signed({1'b0, score});
        case (st)
            IDLE: begin
                mole_nx = '0;
                if (go) begin
                    st_nx    = PLAY;
                    score_nx = '0;
                    rnd_nx   = '0;
                end
            end
            PLAY: begin
                for (int i = 0; i < 4; i++) begin
                    if (hit[i] && mole[i]) begin
                        mole_nx[i] = 1'b0;
                        nhit       = nhit + 3'd1;
                    end else if (hit[i]) begin
`ifdef WRONG_HIT_PENALTY_EN
                        nwrong = nwrong + 3'd1;
`endif
                    end else if (tick) begin
                        if (mole[i]) begin
                            mole_nx[i] = 1'b0;
                            nmiss      = nmiss + 3'd1;
                        end else if (lfsr[4*i +: 4] < 4'd4) begin
                            mole_nx[i] = 1'b1;
                        end
                    end
                end
                score_sum = $signed({1'b0, score}) + $signed({5'b0, nhit})
                          - $signed({5'b0, nmiss}) - $signed({5'b0, nwrong});
                score_nx  = sat_score(score_sum);
                cnt_nx    = tick ? '0 : cnt + CNT_W'(1);
                if (tick) begin
                    rnd_nx = rnd + 8'd1;
                    if (rnd_nx == 8'(GAME_TICKS)) begin
                        st_nx   = OVER;
                        mole_nx = '0;
                        cnt_nx  = '0;
                    end
                end
            end
            OVER: begin
                mole_nx = '0;
                if (go) begin
                    st_nx    = PLAY;
                    score_nx = '0;
                    rnd_nx   = '0;
                end
            end
            default: begin
                st_nx   = IDLE;
                mole_nx = '0;
            end
        endcase
    end

    // State register
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            st <= IDLE;
        end else begin
            st <= st_nx;
        end
    end

    // Game registers: moles, score, round and tick counters
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            mole  <= '0;
            score <= '0;
            rnd   <= '0;
            cnt   <= '0;
        end else begin
            mole  <= mole_nx;
            score <= score_nx;
            rnd   <= rnd_nx;
            cnt   <= cnt_nx;
        end
    end

    // BCD split of the score, one cycle behind it
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            score_tens <= '0;
            score_ones <= '0;
        end else begin
            score_tens <= 4'(score / 7'd10);
            score_ones <= 4'(score % 7'd10);
        end
    end

endmodule

// File: tb/tb_mole_game_ctrl.sv
// tb_mole_game_ctrl: randomized play against a cycle-level reference model of
// the game rules (synchronizer latency, ticks, LFSR pops, saturating score).
module tb_mole_game_ctrl;

    localparam int TD     = 8;
    localparam int GT     = 255;
    localparam int NCYC   = 12000;
    localparam int RST_AT = 5200;

    logic       dclk, clr_n, start, tick;
    logic [3:0] sw, mole, score_tens, score_ones;
    logic [6:0] score;
    logic [1:0] state;

    mole_game_ctrl #(.TICK_DIV(TD), .GAME_TICKS(GT)) dut (
        .dclk(dclk), .clr_n(clr_n), .sw(sw), .start(start),
        .mole(mole), .score(score), .score_tens(score_tens),
        .score_ones(score_ones), .state(state), .tick(tick)
    );

    initial dclk = 1'b0;
    always #5 dclk = ~dclk;

    int n_cmp, n_bad;

    // reference model state: 0 idle, 1 play, 2 over
    int          m_state, m_score, m_prev, m_play_cyc, m_ticks, m_games;
    logic [3:0]  m_mole;
    logic [15:0] m_lfsr;
    logic [3:0]  sw_hist[$];
    logic        st_hist[$];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] want);
        n_cmp++;
        if (obs !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, want, $time);
        end
    endtask

    function automatic int clamp99(input int v);
        return (v < 0) ? 0 : ((v > 99) ? 99 : v);
    endfunction

    function automatic bit model_tick();
        return (m_state == 1) && ((m_play_cyc % TD) == TD - 1);
    endfunction

    task automatic model_reset();
        m_state = 0; m_score = 0; m_prev = 0; m_play_cyc = 0; m_ticks = 0;
        m_mole = 4'd0;
        m_lfsr = 16'hACE1;
        sw_hist = '{4'd0, 4'd0, 4'd0};
        st_hist = '{1'b0, 1'b0, 1'b0};
    endtask

    // one rising edge of the game, given the inputs sampled at that edge
    task automatic model_step(input logic [3:0] s, input logic g);
        logic [3:0]  h, nm;
        logic [15:0] fb;
        logic        gop;
        bit          tk;
        int          delta, nib;
        h   = sw_hist[1] & ~sw_hist[2];
        gop = st_hist[1] & ~st_hist[2];
        tk  = model_tick();
        m_prev = m_score;
        if (m_state == 1) begin
            delta = 0;
            nm = m_mole;
            for (int i = 0; i < 4; i++) begin
                nib = (int'(m_lfsr) >> (4 * i)) % 16;
                if (h[i]) begin
                    if (m_mole[i]) begin
                        nm[i] = 1'b0;
                        delta++;
                    end
`ifdef WRONG_HIT_PENALTY_EN
                    else delta--;
`endif
                end else if (tk) begin
                    if (m_mole[i]) begin
                        nm[i] = 1'b0;
                        delta--;
                    end else if (nib < 4) begin
                        nm[i] = 1'b1;
                    end
                end
            end
            m_score = clamp99(m_score + delta);
            m_mole = nm;
            m_play_cyc++;
            if (tk) begin
                m_ticks++;
                if (m_ticks == GT) begin
                    m_state = 2;
                    m_mole = 4'd0;
                end
            end
        end else if (gop) begin
            m_state = 1; m_score = 0; m_mole = 4'd0;
            m_ticks = 0; m_play_cyc = 0;
            m_games++;
        end
        fb = (m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 16'd1;
        m_lfsr = (m_lfsr >> 1) | (fb << 15);
        sw_hist.push_front(s);
        void'(sw_hist.pop_back());
        st_hist.push_front(g);
        void'(st_hist.pop_back());
    endtask

    task automatic compare_all();
        check("state", 16'(state), 16'(m_state));
        check("mole",  16'(mole),  16'(m_mole));
        check("score", 16'(score), 16'(m_score));
        check("tick",  16'(tick),  16'(model_tick()));
        check("tens",  16'(score_tens), 16'(m_prev / 10));
        check("ones",  16'(score_ones), 16'(m_prev % 10));
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_state"}, 16'(state), 16'd0);
        check({pfx, "_mole"},  16'(mole),  16'd0);
        check({pfx, "_score"}, 16'(score), 16'd0);
        check({pfx, "_tens"},  16'(score_tens), 16'd0);
        check({pfx, "_ones"},  16'(score_ones), 16'd0);
        check({pfx, "_tick"},  16'(tick),  16'd0);
    endtask

    // alternate sloppy and sharp players so both saturation ends get exercised
    task automatic drive();
        int skill;
        skill = (m_games % 2 == 0) ? 95 : 3;
        if ($urandom_range(0, 19) == 0) start = ~start;
        for (int i = 0; i < 4; i++) begin
            if (sw[i]) begin
                if ($urandom_range(0, 1) == 1) sw[i] = 1'b0;
            end else if (m_mole[i]) begin
                if (int'($urandom_range(1, 100)) <= skill) sw[i] = 1'b1;
            end else if (m_state != 1) begin
                if ($urandom_range(0, 9) == 0) sw[i] = 1'b1;
            end else if ($urandom_range(0, 99) == 0) begin
                sw[i] = 1'b1;
            end
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; m_games = 0;
        sw = 4'd0; start = 1'b0;
        clr_n = 1'b1;
        model_reset();
        #1 clr_n = 1'b0;
        #2 check_reset("rst");
        repeat (2) @(negedge dclk);
        clr_n = 1'b1;
        for (int c = 0; c < NCYC; c++) begin
            @(posedge dclk);
            model_step(sw, start);
            #1;
            compare_all();
            drive();
            if (c == RST_AT) begin
                #2 clr_n = 1'b0;
                #1 check_reset("midrst");
                model_reset();
                sw = 4'hF;
                start = 1'b0;
                @(negedge dclk);
                clr_n = 1'b1;
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
